// File: rtl/booth_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : booth_ctrl
//  Purpose  : Sequencing controller for a radix-2 Booth multiplier datapath.
//             Accepts a signed operand pair on a start/busy handshake, loads
//             the operands onto the datapath's shared load bus, steps the
//             add/subtract/shift iterations and captures the 2*WIDTH-bit
//             product from the datapath's A and Q registers.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             start, mcand, mplier - request and operands (sampled at accept)
//             busy, done, product  - handshake status and held result
//             data_out             - operand value onto datapath data_in
//             ldA..ldcnt           - datapath control strobes (registered)
//             q0, qm1, eqz         - datapath decision inputs
//             a_in, q_in           - datapath A/Q registers for the result
//  Revision : 1.0 - initial release
// ============================================================================
module booth_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   data_out,
  output logic               ldA,
  output logic               ldQ,
  output logic               ldM,
  output logic               clrA,
  output logic               clrQ,
  output logic               clrff,
  output logic               sftA,
  output logic               sftQ,
  output logic               addsub,
  output logic               decr,
  output logic               ldcnt,
  input  logic               q0,
  input  logic               qm1,
  input  logic               eqz,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   q_in
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOADM = 3'd1,
    ST_LOADQ = 3'd2,
    ST_CHECK = 3'd3,
    ST_ARITH = 3'd4,
    ST_SHIFT = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic                 op_add_q, op_add_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  // Registered outputs. Each is computed from the next state so that the
  // flopped value equals the decode of the current state.
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     data_out_q, data_out_d;
  logic                 lda_q, lda_d;
  logic                 ldq_q, ldq_d;
  logic                 ldm_q, ldm_d;
  logic                 clra_q, clra_d;
  logic                 clrq_q, clrq_d;
  logic                 clrff_q, clrff_d;
  logic                 sfta_q, sfta_d;
  logic                 sftq_q, sftq_d;
  logic                 addsub_q, addsub_d;
  logic                 decr_q, decr_d;
  logic                 ldcnt_q, ldcnt_d;

  // Next-state and datapath-result logic
  always_comb begin
    state_d   = state_q;
    op_add_d  = op_add_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = mcand;
          mplier_d = mplier;
          state_d  = ST_LOADM;
        end
      end
      ST_LOADM: state_d = ST_LOADQ;
      ST_LOADQ: state_d = ST_CHECK;
      ST_CHECK: begin
        // The counter reaches zero only after the last shift, so the
        // datapath holds the finished product in A:Q at this point.
        if (eqz) begin
          product_d = {a_in, q_in};
          state_d   = ST_DONE;
        end else begin
          case ({q0, qm1})
            2'b01: begin
              op_add_d = 1'b1;
              state_d  = ST_ARITH;
            end
            2'b10: begin
              op_add_d = 1'b0;
              state_d  = ST_ARITH;
            end
            default: state_d = ST_SHIFT;
          endcase
        end
      end
      // The add/subtract choice is already held in op_add, so any change
      // of qm1 during ARITH does not affect this iteration.
      ST_ARITH: state_d = ST_SHIFT;
      ST_SHIFT: state_d = ST_CHECK;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state, flopped below
  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    clrq_d     = (state_d == ST_IDLE);
    ldm_d      = (state_d == ST_LOADM);
    ldcnt_d    = (state_d == ST_LOADM);
    clra_d     = (state_d == ST_LOADM);
    ldq_d      = (state_d == ST_LOADQ);
    clrff_d    = (state_d == ST_LOADQ);
    lda_d      = (state_d == ST_ARITH);
    addsub_d   = (state_d == ST_ARITH) && op_add_d;
    sfta_d     = (state_d == ST_SHIFT);
    sftq_d     = (state_d == ST_SHIFT);
    decr_d     = (state_d == ST_SHIFT);
    data_out_d = '0;
    if (state_d == ST_LOADM) begin
      data_out_d = mcand_d;
    end else if (state_d == ST_LOADQ) begin
      data_out_d = mplier_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_add_q   <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      product_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
      lda_q      <= 1'b0;
      ldq_q      <= 1'b0;
      ldm_q      <= 1'b0;
      clra_q     <= 1'b0;
      clrq_q     <= 1'b0;
      clrff_q    <= 1'b0;
      sfta_q     <= 1'b0;
      sftq_q     <= 1'b0;
      addsub_q   <= 1'b0;
      decr_q     <= 1'b0;
      ldcnt_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_add_q   <= op_add_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      product_q  <= product_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
      lda_q      <= lda_d;
      ldq_q      <= ldq_d;
      ldm_q      <= ldm_d;
      clra_q     <= clra_d;
      clrq_q     <= clrq_d;
      clrff_q    <= clrff_d;
      sfta_q     <= sfta_d;
      sftq_q     <= sftq_d;
      addsub_q   <= addsub_d;
      decr_q     <= decr_d;
      ldcnt_q    <= ldcnt_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign product  = product_q;
  assign data_out = data_out_q;
  assign ldA      = lda_q;
  assign ldQ      = ldq_q;
  assign ldM      = ldm_q;
  assign clrA     = clra_q;
  assign clrQ     = clrq_q;
  assign clrff    = clrff_q;
  assign sftA     = sfta_q;
  assign sftQ     = sftq_q;
  assign addsub   = addsub_q;
  assign decr     = decr_q;
  assign ldcnt    = ldcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_ctrl
//  Purpose  : Directed self-checking bench for booth_ctrl, with a behavioural
//             Booth datapath attached to the controller's strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_booth_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] mcand = '0;
  logic [15:0] mplier = '0;
  logic        busy, done;
  logic [31:0] product;
  logic [15:0] data_out;
  logic        ldA, ldQ, ldM, clrA, clrQ, clrff, sftA, sftQ, addsub, decr, ldcnt;
  logic        q0, qm1, eqz;
  logic [15:0] a_in, q_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product), .data_out(data_out),
    .ldA(ldA), .ldQ(ldQ), .ldM(ldM), .clrA(clrA), .clrQ(clrQ), .clrff(clrff),
    .sftA(sftA), .sftQ(sftQ), .addsub(addsub), .decr(decr), .ldcnt(ldcnt),
    .q0(q0), .qm1(qm1), .eqz(eqz), .a_in(a_in), .q_in(q_in)
  );

  // Behavioural datapath. A carries a guard bit so the arithmetic shift
  // keeps the true sign even for -2^15 * -2^15.
  logic [16:0] dp_a = '0;
  logic [15:0] dp_q = '0;
  logic [15:0] dp_m = '0;
  logic        dp_qm1 = 1'b0;
  logic [4:0]  dp_cnt = '0;

  always @(posedge clk) begin
    if (clrA) dp_a <= '0;
    else if (ldA) dp_a <= addsub ? dp_a + {dp_m[15], dp_m} : dp_a - {dp_m[15], dp_m};
    else if (sftA) dp_a <= {dp_a[16], dp_a[16:1]};
    if (clrQ) dp_q <= '0;
    else if (ldQ) dp_q <= data_out;
    else if (sftQ) dp_q <= {dp_a[0], dp_q[15:1]};
    if (ldM) dp_m <= data_out;
    dp_qm1 <= clrff ? 1'b0 : dp_q[0];
    if (ldcnt) dp_cnt <= 5'd16;
    else if (decr) dp_cnt <= dp_cnt - 5'd1;
  end

  assign q0   = dp_q[0];
  assign qm1  = dp_qm1;
  assign eqz  = (dp_cnt == 5'd0);
  assign a_in = dp_a[15:0];
  assign q_in = dp_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Steps from the current negedge until done is seen (bounded), collecting
  // ARITH/SHIFT statistics. cyc is the cycle index relative to the accept edge.
  task automatic wait_done(input int from, input int poke_cyc, output int cyc,
                           output int nar, output int nsh,
                           output logic [15:0] pat, output int bad);
    cyc = from; nar = 0; nsh = 0; pat = '0; bad = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy !== 1'b1) bad++;
      if (ldA === 1'b1) begin
        nar++;
        pat = {pat[14:0], addsub};
      end
      if (sftA === 1'b1) nsh++;
      if (poke_cyc != 0) start = (cyc == poke_cyc);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic do_op(input logic [15:0] mc, input logic [15:0] mp,
                       input logic [31:0] exp_p, input int exp_lat,
                       input int exp_k, input logic [15:0] exp_pat,
                       input int poke_cyc, input bit poke_done, input string tag);
    int cyc, nar, nsh, bad;
    logic [15:0] pat;
    @(negedge clk);
    mcand = mc; mplier = mp; start = 1'b1;
    @(negedge clk);                        // E0+1
    start = 1'b0; mcand = 16'hDEAD; mplier = 16'hBEEF;
    chk({tag, ":busy1"}, busy, 1);
    chk({tag, ":strb1"}, {ldM, ldcnt, clrA, ldQ, clrff, clrQ, ldA, sftA}, 8'b1110_0000);
    chk({tag, ":dout1"}, data_out, mc);
    @(negedge clk);                        // E0+2
    chk({tag, ":strb2"}, {ldM, ldcnt, clrA, ldQ, clrff, clrQ, ldA, sftA}, 8'b0001_1000);
    chk({tag, ":dout2"}, data_out, mp);
    wait_done(2, poke_cyc, cyc, nar, nsh, pat, bad);
    chk({tag, ":latency"}, cyc, exp_lat);
    chk({tag, ":product"}, product, exp_p);
    chk({tag, ":arith"}, nar, exp_k);
    chk({tag, ":addsub"}, pat, exp_pat);
    chk({tag, ":shifts"}, nsh, 16);
    chk({tag, ":busylow"}, bad, 0);
    chk({tag, ":busydone"}, busy, 1);
    if (poke_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ":donepulse"}, done, 0);
    chk({tag, ":idle"}, busy, 0);
    if (poke_done) begin
      @(negedge clk);
      chk({tag, ":noaccept"}, busy, 0);
      chk({tag, ":prodheld"}, product, exp_p);
    end
  endtask

  initial begin
    int cyc, nar, nsh, bad, seen;
    logic [15:0] pat;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:product", product, 0);
    chk("rst:dout", data_out, 0);
    chk("rst:strobes", {ldA, ldQ, ldM, clrA, clrQ, clrff, sftA, sftQ, addsub, decr, ldcnt}, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op(16'h0003, 16'h0005, 32'h0000_000F, 40, 4,  16'h0005, 0, 0, "p3x5");
    do_op(16'hFFFD, 16'h0005, 32'hFFFF_FFF1, 40, 4,  16'h0005, 0, 0, "m3x5");
    do_op(16'h8000, 16'h8000, 32'h4000_0000, 37, 1,  16'h0000, 0, 0, "minsq");
    do_op(16'h7FFF, 16'h8000, 32'hC000_8000, 37, 1,  16'h0000, 0, 0, "maxmin");
    do_op(16'h1234, 16'h0000, 32'h0000_0000, 36, 0,  16'h0000, 0, 0, "zero");
    do_op(16'h0003, 16'h5555, 32'h0000_FFFF, 52, 16, 16'h5555, 0, 0, "alt");
    do_op(16'h0064, 16'hFF9C, 32'hFFFF_D8F0, 39, 3,  16'h0002, 10, 1, "poke");

    // start held high: back-to-back operations with one IDLE cycle between
    @(negedge clk);
    mcand = 16'h0003; mplier = 16'h0005; start = 1'b1;
    @(negedge clk);
    mcand = 16'h0007; mplier = 16'hFFFE;
    wait_done(1, 0, cyc, nar, nsh, pat, bad);
    start = 1'b1;
    chk("b2b1:latency", cyc, 40);
    chk("b2b1:product", product, 32'h0000_000F);
    @(negedge clk);
    chk("b2b:idlegap", busy, 0);
    @(negedge clk);
    chk("b2b:reaccept", {busy, ldM}, 2'b11);
    chk("b2b:dout", data_out, 16'h0007);
    start = 1'b0;
    wait_done(1, 0, cyc, nar, nsh, pat, bad);
    chk("b2b2:latency", cyc, 37);
    chk("b2b2:product", product, 32'hFFFF_FFF2);
    @(negedge clk);

    // Reset during the 10th SHIFT
    @(negedge clk);
    mcand = 16'h0003; mplier = 16'h0005; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nsh = 0; cyc = 1;
    while (nsh < 10 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (sftA === 1'b1) nsh++;
    end
    chk("mrst:reached", nsh, 10);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst:busy", busy, 0);
    chk("mrst:product", product, 0);
    chk("mrst:done", done, 0);
    chk("mrst:strobes", {ldA, ldQ, ldM, clrA, sftA, sftQ, decr, ldcnt}, 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("mrst:quiet", seen, 0);
    do_op(16'h0003, 16'h0005, 32'h0000_000F, 40, 4, 16'h0005, 0, 0, "after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
